// File: rtl/seq_restoring_divider_16_pkg.sv
// rtl/seq_restoring_divider_16_pkg.sv - shared types and constants for the restoring divider
// Holds the FSM encoding and default widths used by the divider, its interface and its subtractor.
package seq_restoring_divider_16_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = 5;
  localparam int CLA_GROUP = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_restoring_divider_16_if.sv
// rtl/seq_restoring_divider_16_if.sv - start/done operand and result bundle for the divider
// The master issues operands and start; the slave (divider) returns busy/done and registered results.
interface seq_restoring_divider_16_if
  import seq_restoring_divider_16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );

endinterface

// File: rtl/seq_restoring_divider_16_cla_sub_nb.sv
// rtl/seq_restoring_divider_16_cla_sub_nb.sv - N-bit subtractor a + ~b + 1 on a carry-lookahead adder
// Borrow is the inverted carry-out; carries are formed per lookahead group from the group carry-in.
module cla_sub_nb
  import seq_restoring_divider_16_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N-1:0] b_n;
  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;
  logic         grp_c;

  assign b_n  = ~b;
  assign gen  = a & b_n;
  assign prop = a ^ b_n;

  // Each carry inside a group is expanded directly from that group's carry-in.
  always_comb begin
    carry    = '0;
    grp_c    = 1'b0;
    carry[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      grp_c = carry[i - (i % CLA_GROUP)];
      for (int j = i - (i % CLA_GROUP); j <= i; j++) begin
        grp_c = gen[j] | (prop[j] & grp_c);
      end
      carry[i+1] = grp_c;
    end
  end

  assign diff   = prop ^ carry[N-1:0];
  assign borrow = ~carry[N];

endmodule

// File: rtl/seq_restoring_divider_16.sv
// rtl/seq_restoring_divider_16.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// Trial-subtracts the shifted partial remainder each cycle and restores on borrow; start/done handshake.
module seq_restoring_divider_16
  import seq_restoring_divider_16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic clk,
  input  logic rst,
  seq_restoring_divider_16_if.slave bus
);

  div_state_t       state_q;
  div_state_t       state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             accept;
  logic             zero_div;
  logic             last_iter;
  logic [1:0]       unused_bits;

  assign accept    = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign zero_div  = (bus.divisor == '0);
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));

  // Before any shift the partial remainder has fewer significant bits than iterations done,
  // so its top bit is always clear and can be dropped from the shifted value.
  assign shifted = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};

  cla_sub_nb #(
    .N(WIDTH + 1)
  ) u_trial_sub (
    .a      ({1'b0, shifted}),
    .b      ({1'b0, dsr_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  assign rem_next    = borrow ? shifted : trial[WIDTH-1:0];
  assign quo_next    = {quo_q[WIDTH-2:0], ~borrow};
  assign unused_bits = {trial[WIDTH], rem_q[WIDTH-1]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = zero_div ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dsr_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (zero_div) begin
          quotient_q  <= '1;
          remainder_q <= bus.dividend;
          dbz_q       <= 1'b1;
        end else begin
          rem_q   <= '0;
          quo_q   <= bus.dividend;
          dsr_q   <= bus.divisor;
          count_q <= '0;
          dbz_q   <= 1'b0;
        end
      end else if (state_q == S_RUN) begin
        rem_q   <= rem_next;
        quo_q   <= quo_next;
        count_q <= count_q + CNT_W'(1);
        if (last_iter) begin
          quotient_q  <= quo_next;
          remainder_q <= rem_next;
        end
      end
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider_16.sv
// tb/tb_seq_restoring_divider_16.sv - self-checking bench for seq_restoring_divider_16
// An arithmetic reference model is compared every cycle; directed vectors pin it with literal results.
module tb_seq_restoring_divider_16;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  seq_restoring_divider_16_if #(.WIDTH(16)) bus ();

  seq_restoring_divider_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: an accepted op finishes 16 edges later with a/b and a%b.
  int          m_left = 0;
  logic        m_valid = 1'b0;
  logic        m_busy, m_done, m_dbz;
  logic [15:0] m_q, m_r, m_a, m_b;

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b1;
      m_left  <= 0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_dbz   <= 1'b0;
      m_q     <= 16'd0;
      m_r     <= 16'd0;
      m_a     <= 16'd0;
      m_b     <= 16'd0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      m_busy <= (m_left > 1);
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_q <= m_a / m_b;
        m_r <= m_a % m_b;
      end
    end else begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      if (bus.start) begin
        m_a <= bus.dividend;
        m_b <= bus.divisor;
        if (bus.divisor == 16'd0) begin
          m_done <= 1'b1;
          m_q    <= 16'hFFFF;
          m_r    <= bus.dividend;
          m_dbz  <= 1'b1;
        end else begin
          m_left <= 16;
          m_busy <= 1'b1;
          m_dbz  <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", bus.busy, m_busy);
      check("done", bus.done, m_done);
      check("quotient", bus.quotient, m_q);
      check("remainder", bus.remainder, m_r);
      check("div_by_zero", bus.div_by_zero, m_dbz);
      if (m_done && !m_dbz) begin
        check("invariant", 32'(bus.quotient) * 32'(m_b) + 32'(bus.remainder), 32'(m_a));
        check("rem_lt_div", 32'(bus.remainder < m_b), 32'd1);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'hA5A5;
    bus.divisor  = 16'h0000;
  endtask

  task automatic wait_done(input int t0, output int lat, output int busy_seen);
    int n;
    n = 0;
    busy_seen = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_seen++;
      @(negedge clk);
      n++;
    end
    if (bus.done) begin
      lat = cyc - t0;
    end else begin
      lat = -1;
      check("done_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                        input int elat, input int ebusy, input bit gap);
    int t0, lat, bs;
    t0 = cyc;
    issue(a, b);
    wait_done(t0, lat, bs);
    check("latency", lat, elat);
    check("busy_cycles", bs, ebusy);
    check("op_quotient", bus.quotient, eq);
    check("op_remainder", bus.remainder, er);
    check("op_dbz", bus.div_by_zero, edbz);
    if (gap) begin
      @(negedge clk);
      check("done_pulse_width", bus.done, 1'b0);
      check("quotient_hold", bus.quotient, eq);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[8] = '{
    '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0},
    '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0},
    '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0},
    '{16'd3,     16'd10,     16'd0,      16'd3,      1'b0},
    '{16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1},
    '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0},
    '{16'h8000,  16'h8001,   16'd0,      16'h8000,   1'b0},
    '{16'hFFFF,  16'h8000,   16'd1,      16'h7FFF,   1'b0}
  };

  initial begin
    int t0, lat, bs, dones;
    logic [15:0] a, b;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'd0;
    bus.divisor  = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_quotient", bus.quotient, 16'd0);
    check("rst_remainder", bus.remainder, 16'd0);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz,
             vecs[i].dbz ? 1 : 17, vecs[i].dbz ? 0 : 16, 1'b1);
    end

    // Back-to-back: second start lands in the DONE cycle; start pulses while busy are ignored.
    t0 = cyc;
    issue(16'd1000, 16'd3);
    wait_done(t0, lat, bs);
    check("b2b1_latency", lat, 17);
    check("b2b1_quotient", bus.quotient, 16'd333);
    check("b2b1_remainder", bus.remainder, 16'd1);
    t0 = cyc;
    issue(16'd9, 16'd4);
    repeat (2) @(negedge clk);
    issue(16'd77, 16'd0);
    repeat (2) @(negedge clk);
    issue(16'd500, 16'd2);
    wait_done(t0, lat, bs);
    check("b2b2_latency", lat, 17);
    check("b2b2_quotient", bus.quotient, 16'd2);
    check("b2b2_remainder", bus.remainder, 16'd1);
    check("b2b2_dbz", bus.div_by_zero, 1'b0);
    @(negedge clk);
    check("b2b2_done_pulse", bus.done, 1'b0);
    check("b2b2_hold", bus.quotient, 16'd2);

    // Reset in cycle 8 of a run aborts it without a done pulse.
    t0 = cyc;
    issue(16'd100, 16'd7);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_quotient", bus.quotient, 16'd0);
    check("abort_remainder", bus.remainder, 16'd0);
    check("abort_dbz", bus.div_by_zero, 1'b0);
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 17, 16, 1'b1);

    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 15));
        2:       b = 16'($urandom_range(16'h8000, 16'hFFFF));
        default: b = 16'($urandom);
      endcase
      if (b == 16'd0) run_op(a, b, 16'hFFFF, a, 1'b1, 1, 0, 1'($urandom_range(0, 1)));
      else            run_op(a, b, a / b, a % b, 1'b0, 17, 16, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
